// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: one outstanding IMEM read feeding a DEPTH-entry {pc, insn} queue.
// Branch redirects flush the queue and squash any read still in flight.
module fetch_prefetch #(
    parameter logic [31:0] BASE_ADDR = 32'h80020000,
    parameter int          DEPTH     = 4,
    parameter logic [1:0]  WORD_SIZE = 2'b00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        do_branch_i,
    input  logic [31:0] pc_effective_i,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        i_mem_enable_o,
    output logic [31:0] address_o,
    output logic        rw_o,
    output logic [1:0]  access_size_o,
    output logic        valid_out_o,
    output logic [31:0] pc_out_o,
    output logic [31:0] insn_out_o
);
    // DEPTH must be a power of two so the pointers wrap by natural overflow.
    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_insn_q [DEPTH];

    logic req, resp, push, pop, valid;
    logic unused_pc_lsbs;

    assign unused_pc_lsbs = ^pc_effective_i[1:0];

    // A request is only issued while idle, so count < DEPTH also reserves a slot for it.
    assign valid          = (count_q != '0);
    assign i_mem_enable_o = !rst_i && !busy_q && !do_branch_i && (count_q < FULL);
    assign address_o      = fetch_pc_q;
    assign rw_o           = 1'b1;
    assign access_size_o  = WORD_SIZE;
    assign valid_out_o    = valid;
    assign pc_out_o       = valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    assign insn_out_o     = valid ? fifo_insn_q[rd_ptr_q] : 32'h0;

    assign req  = i_mem_enable_o && mem_ready_i;
    assign resp = busy_q && mem_rvalid_i;
    assign push = resp && !drop_q && !do_branch_i;
    assign pop  = valid && !stall_i && !do_branch_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        busy_d     = busy_q;
        drop_d     = drop_q;

        if (req) begin
            busy_d     = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (resp) begin
            busy_d = 1'b0;
            drop_d = 1'b0;
        end

        if (do_branch_i) begin
            fetch_pc_d = {pc_effective_i[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if (busy_q && !mem_rvalid_i) drop_d = 1'b1;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= BASE_ADDR;
            req_pc_q   <= 32'h0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_insn_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a 1-cycle IMEM responder plus a queue of expected
// {pc, insn} entries that are checked as the decode side pops them.
module tb_fetch_prefetch;
    localparam logic [31:0] BASE  = 32'h80020000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        do_branch;
    logic [31:0] pc_effective;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        i_mem_enable;
    logic [31:0] address;
    logic        rw;
    logic [1:0]  access_size;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] insn_out;

    int checks = 0;
    int errors = 0;

    // Expected-state model and responder state
    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_busy;
    logic        m_drop;
    logic        auto_mem;
    logic        force_rv;
    logic        mem_pending;
    logic [31:0] mem_addr;
    logic        found;

    fetch_prefetch #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .WORD_SIZE(2'b00)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .do_branch_i   (do_branch),
        .pc_effective_i(pc_effective),
        .mem_ready_i   (mem_ready),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .i_mem_enable_o(i_mem_enable),
        .address_o     (address),
        .rw_o          (rw),
        .access_size_o (access_size),
        .valid_out_o   (valid_out),
        .pc_out_o      (pc_out),
        .insn_out_o    (insn_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock: drive responder, check outputs against the model, advance the model.
    task automatic step();
        logic exp_en, exp_valid, pop, req, resp;
        mem_rvalid = force_rv || (auto_mem && mem_pending);
        mem_rdata  = mem_rvalid ? insn_of(mem_addr) : 32'h0BADF00D;
        #1;
        if (rst) begin
            chk("rst_i_mem_enable", {31'b0, i_mem_enable}, 32'h0);
            chk("rst_valid_out", {31'b0, valid_out}, 32'h0);
            chk("rst_pc_out", pc_out, 32'h0);
            chk("rst_insn_out", insn_out, 32'h0);
            sb.delete();
            m_pc        = BASE;
            m_busy      = 1'b0;
            m_drop      = 1'b0;
            mem_pending = 1'b0;
        end else begin
            exp_en = !m_busy && !do_branch && (sb.size() < DEPTH);
            chk("i_mem_enable", {31'b0, i_mem_enable}, {31'b0, exp_en});
            if (exp_en) chk("address", address, m_pc);
            chk("rw", {31'b0, rw}, 32'h1);
            chk("access_size", {30'b0, access_size}, 32'h0);
            exp_valid = (sb.size() != 0);
            chk("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
            if (exp_valid) begin
                chk("pc_out", pc_out, sb[0][63:32]);
                chk("insn_out", insn_out, sb[0][31:0]);
            end else begin
                chk("bubble_pc_out", pc_out, 32'h0);
            end
            pop  = exp_valid && !stall && !do_branch;
            resp = m_busy && mem_rvalid;
            req  = exp_en && mem_ready;
            if (do_branch) begin
                sb.delete();
                m_pc = {pc_effective[31:2], 2'b00};
                if (m_busy && !mem_rvalid) m_drop = 1'b1;
            end else begin
                if (pop) void'(sb.pop_front());
                if (resp && !m_drop) sb.push_back({m_req_pc, mem_rdata});
            end
            if (resp) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            if (mem_rvalid) mem_pending = 1'b0;
            if (req) begin
                m_busy      = 1'b1;
                m_req_pc    = m_pc;
                m_pc        = m_pc + 32'd4;
                mem_pending = 1'b1;
                mem_addr    = m_req_pc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        do_branch    = 1'b0;
        pc_effective = 32'h0;
        mem_ready    = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = 32'h0;
        auto_mem     = 1'b0;
        force_rv     = 1'b0;
        mem_pending  = 1'b0;
        mem_addr     = 32'h0;
        m_pc         = BASE;
        m_req_pc     = 32'h0;
        m_busy       = 1'b0;
        m_drop       = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();

        // Streaming from reset with a 1-cycle memory
        rst       = 1'b0;
        mem_ready = 1'b1;
        auto_mem  = 1'b1;
        chk("first_req_address", address, BASE);
        repeat (10) step();

        // Stall holds: queue fills to DEPTH, then drains in consecutive cycles
        stall = 1'b1;
        repeat (10) step();
        stall = 1'b0;
        repeat (8) step();

        // Redirect while a read is in flight: response dropped, realigned target
        auto_mem = 1'b0;
        stall    = 1'b1;
        repeat (2) step();
        do_branch    = 1'b1;
        pc_effective = 32'h80020043;
        step();
        do_branch = 1'b0;
        stall     = 1'b0;
        auto_mem  = 1'b1;
        repeat (8) step();

        // Redirect in the same cycle as a response and a pop
        stall = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (mem_pending && sb.size() != 0) found = 1'b1;
            else step();
        end
        chk("find_resp_with_entry", {31'b0, found}, 32'h1);
        stall        = 1'b0;
        do_branch    = 1'b1;
        pc_effective = 32'h80021000;
        step();
        do_branch = 1'b0;
        chk("post_branch_valid_out", {31'b0, valid_out}, 32'h0);
        chk("post_branch_pc_out", pc_out, 32'h0);
        repeat (6) step();

        // Fetch PC wrap at the top of the address space
        do_branch    = 1'b1;
        pc_effective = 32'hFFFFFFFC;
        step();
        do_branch = 1'b0;
        repeat (8) step();

        // Reset while busy, then a spurious response
        auto_mem = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        mem_ready = 1'b0;
        force_rv  = 1'b1;
        step();
        force_rv = 1'b0;
        repeat (3) step();
        chk("spurious_valid_out", {31'b0, valid_out}, 32'h0);
        mem_ready = 1'b1;
        auto_mem  = 1'b1;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter BASE_ADDR, default 32'h80020000, reset fetch PC.
REQ-002 Parameter DEPTH, default 4, instruction-queue entries; SHALL be a power of two, >= 2.
REQ-003 Parameter WORD_SIZE, default 2'b00, value driven on access_size.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  decode cannot accept an instruction this cycle.
REQ-007 do_branch  input  1  execute redirect request.
REQ-008 pc_effective  input  32  redirect target.
REQ-009 mem_ready  input  1  IMEM accepts the request this cycle.
REQ-010 mem_rvalid  input  1  IMEM read data valid this cycle.
REQ-011 mem_rdata  input  32  IMEM read data.
REQ-012 i_mem_enable  output  1  request valid to IMEM.
REQ-013 address  output  32  request address.
REQ-014 rw  output  1  constant 1 (read).
REQ-015 access_size  output  2  constant WORD_SIZE.
REQ-016 valid_out  output  1  pc_out/insn_out hold a fetched instruction.
REQ-017 pc_out  output  32  PC of queue head.
REQ-018 insn_out  output  32  instruction of queue head.

Function
REQ-019 Block SHALL hold a fetch PC, a DEPTH-entry FIFO of {pc, insn}, a count 0..DEPTH, and one outstanding-request tracker {busy, req_pc, drop}.
REQ-020 At most one IMEM request SHALL be outstanding.
REQ-021 i_mem_enable SHALL be 1 iff !busy, !do_branch, and count < DEPTH; address SHALL equal fetch PC.
REQ-022 Request accepted when i_mem_enable && mem_ready: busy<=1, req_pc<=fetch PC, fetch PC<=fetch PC+4 (modulo 2^32, 32'hFFFFFFFC wraps to 0).
REQ-023 mem_rvalid while busy SHALL clear busy and, if drop==0, push {req_pc, mem_rdata}; mem_rvalid while !busy SHALL be ignored.
REQ-024 A response SHALL be accepted no earlier than the cycle after its request.
REQ-025 valid_out SHALL equal (count != 0), driven from registered state; insn_out/pc_out SHALL show FIFO head; pc_out SHALL be 32'h0 when valid_out==0 (bubble).
REQ-026 Pop SHALL occur when valid_out && !stall; read/write pointers wrap modulo DEPTH.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; push when full cannot occur (guaranteed by REQ-021 counting busy as reserved: request only if count + busy < DEPTH).
REQ-028 do_branch SHALL, on that edge: set fetch PC <= {pc_effective[31:2], 2'b00}, count and pointers <= 0, and if busy with no response this cycle set drop<=1.
REQ-029 do_branch SHALL override same-cycle push and pop; a response arriving in the branch cycle SHALL be discarded.
REQ-030 drop SHALL clear when the dropped response arrives; new requests wait until busy==0.
REQ-031 stall SHALL not block fetching; the queue fills to DEPTH and then i_mem_enable falls.
REQ-032 Latency: mem_rvalid at edge N -> valid_out=1 with that instruction after edge N (if queue was empty).

Reset
REQ-033 While reset==1: fetch PC=BASE_ADDR, count=0, pointers=0, busy=0, drop=0, valid_out=0, pc_out=0, insn_out=0, i_mem_enable=0.
REQ-034 First cycle after reset release SHALL assert i_mem_enable with address=BASE_ADDR.
REQ-035 Reset mid-operation SHALL discard queue and any outstanding request; a later mem_rvalid SHALL be ignored.

Verification
REQ-036 Reset release, mem_ready=1, 1-cycle IMEM -> requests 80020000, 80020004, ...; valid_out streams pc_out in order, insn_out matches IMEM.
REQ-037 stall=1 held, memory always ready -> exactly DEPTH (4) entries queued, i_mem_enable=0; release stall -> 4 pops in consecutive cycles, fetching resumes.
REQ-038 do_branch with pc_effective=32'h80020043 while request outstanding -> queue empties, in-flight response dropped, next request address 32'h80020040.
REQ-039 do_branch in same cycle as mem_rvalid and pop -> no push, valid_out=0 next cycle, pc_out=0.
REQ-040 Fetch PC at 32'hFFFFFFFC -> next request address 32'h00000000.
REQ-041 Assert reset while busy, then spurious mem_rvalid -> no entry pushed, valid_out stays 0.
